// File: rtl/cpu_control_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_control_sequencer_if
//
// Purpose
//   Bundles the signals between the control sequencer and the rest of the
//   6-bit CPU (program/data memory, accumulator, ALU and operand mux).
//
// Signal summary
//   instr_in  [5:0]      instruction word from program memory
//   mem_ready            memory handshake: data valid this cycle
//   acc_zero             accumulator == 0 flag
//   pc        [PC_W-1:0] current program counter
//   mem_req              memory access request (fetch or LD)
//   src_sel   [1:0]      operand mux select: 00=R[n], 01=imm, 10=ALU, 11=mem
//   operand   [2:0]      IR[2:0], register index or immediate
//   alu_op               0=ADD, 1=SUB, meaningful while alu_en=1
//   alu_en               ALU computes this cycle
//   acc_we               accumulator write strobe
//   halted               sticky halt indicator
//
// Modports
//   master : the sequencer itself (drives the control outputs)
//   slave  : the datapath / memory side (drives instr_in, mem_ready, acc_zero)
// -----------------------------------------------------------------------------
interface cpu_control_sequencer_if #(
    parameter int PC_W = 6
);
    logic [5:0]      instr_in;
    logic            mem_ready;
    logic            acc_zero;
    logic [PC_W-1:0] pc;
    logic            mem_req;
    logic [1:0]      src_sel;
    logic [2:0]      operand;
    logic            alu_op;
    logic            alu_en;
    logic            acc_we;
    logic            halted;

    modport master (
        input  instr_in,
        input  mem_ready,
        input  acc_zero,
        output pc,
        output mem_req,
        output src_sel,
        output operand,
        output alu_op,
        output alu_en,
        output acc_we,
        output halted
    );

    modport slave (
        output instr_in,
        output mem_ready,
        output acc_zero,
        input  pc,
        input  mem_req,
        input  src_sel,
        input  operand,
        input  alu_op,
        input  alu_en,
        input  acc_we,
        input  halted
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_control_sequencer
//
// Purpose
//   Multi-cycle FETCH / DECODE / EXEC / WB sequencer for the 6-bit CPU. Owns
//   the program counter and the instruction register, and drives the select
//   of the operand/writeback mux feeding the accumulator together with the
//   ALU, memory and accumulator-write strobes.
//
// Ports
//   clk   : single clock, rising edge
//   rst   : synchronous, active-high reset (priority in every state)
//   bus   : cpu_control_sequencer_if.master, see the interface header for the
//           individual signals
//
// Parameters
//   PC_W     : program counter width (must be > 3, JZ replaces pc[2:0])
//   RESET_PC : program counter value loaded on reset
//
// Instruction set (IR[5:3])
//   000 NOP  001 LDI  010 MOV  011 ADD  100 SUB  101 LD  110 JZ  111 HLT
//
// Cycle counts with zero-wait memory
//   NOP/JZ  : FETCH, DECODE                 (2)
//   LDI/MOV : FETCH, DECODE, WB             (3)
//   ADD/SUB : FETCH, DECODE, EXEC, WB       (4)
//   LD      : FETCH, DECODE, EXEC, WB       (4, EXEC stretches on wait)
// -----------------------------------------------------------------------------
module cpu_control_sequencer #(
    parameter int              PC_W     = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    cpu_control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_LD  = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;
    localparam logic [1:0] SRC_ALU = 2'b10;
    localparam logic [1:0] SRC_MEM = 2'b11;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [5:0]      ir_q, ir_d;
    logic [2:0]      opcode;

    assign opcode = ir_q[5:3];

    // Writeback source for the instruction held in IR. MOV and anything that
    // never reaches WB fall back to the register-file path.
    function automatic logic [1:0] wbSource(input logic [2:0] op);
        logic [1:0] sel;
        sel = SRC_REG;
        case (op)
            OP_LDI:         sel = SRC_IMM;
            OP_ADD, OP_SUB: sel = SRC_ALU;
            OP_LD:          sel = SRC_MEM;
            default:        sel = SRC_REG;
        endcase
        return sel;
    endfunction

    // State, PC and IR registers. Reset wins over everything, including a
    // pending memory wait and the absorbing HALT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic. IR only loads on the fetch handshake, and the PC
    // increments at the same moment so JZ in DECODE sees the already
    // incremented PC and only replaces its low three bits. mem_ready is
    // looked at only in FETCH and in EXEC of LD; elsewhere it is ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.instr_in;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                case (opcode)
                    OP_HLT: state_d = ST_HALT;
                    OP_NOP: state_d = ST_FETCH;
                    OP_JZ: begin
                        if (bus.acc_zero) begin
                            pc_d = {pc_q[PC_W-1:3], ir_q[2:0]};
                        end
                        state_d = ST_FETCH;
                    end
                    OP_LDI, OP_MOV: state_d = ST_WB;
                    default:        state_d = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                if (opcode == OP_LD) begin
                    if (bus.mem_ready) begin
                        state_d = ST_WB;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end

            ST_WB: state_d = ST_FETCH;

            ST_HALT: state_d = ST_HALT;

            default: state_d = ST_FETCH;
        endcase
    end

    // Output decode, purely from state and IR so there is no combinational
    // path from mem_ready to any strobe. In EXEC the mux select already shows
    // the writeback source so the mux has a full cycle to settle before WB.
    // mem_req is high in every FETCH cycle, including the first one after
    // reset, since that is the instruction fetch request.
    always_comb begin
        bus.mem_req = 1'b0;
        bus.src_sel = SRC_REG;
        bus.alu_en  = 1'b0;
        bus.alu_op  = 1'b0;
        bus.acc_we  = 1'b0;
        bus.halted  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                bus.mem_req = 1'b1;
            end

            ST_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        bus.alu_en  = 1'b1;
                        bus.alu_op  = ir_q[5];
                        bus.src_sel = SRC_ALU;
                    end
                    OP_LD: begin
                        bus.mem_req = 1'b1;
                        bus.src_sel = SRC_MEM;
                    end
                    default: begin
                        bus.src_sel = SRC_REG;
                    end
                endcase
            end

            ST_WB: begin
                bus.acc_we  = 1'b1;
                bus.src_sel = wbSource(opcode);
            end

            ST_HALT: begin
                bus.halted = 1'b1;
            end

            default: begin
                bus.mem_req = 1'b0;
            end
        endcase
    end

    assign bus.pc      = pc_q;
    assign bus.operand = ir_q[2:0];

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_sequencer
//
// Self-checking bench for cpu_control_sequencer. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
// The reference model works per instruction: it knows the cycle timeline of
// each opcode (FETCH waits, DECODE, optional EXEC with LD waits, optional WB)
// and keeps the architectural PC and IR as plain integers.
// -----------------------------------------------------------------------------
module tb_cpu_control_sequencer;

    logic clk;
    logic rst;

    cpu_control_sequencer_if #(.PC_W(6)) bus ();

    cpu_control_sequencer #(
        .PC_W     (6),
        .RESET_PC (6'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Architectural state as the model sees it.
    logic [5:0] modelPc;
    logic [5:0] modelIr;

    typedef struct {
        logic [5:0] instr;
        bit         az;
        int         lat;
        int         weCount;
        logic [1:0] weSrc;
        int         aluCount;
        bit         aluOp;
    } vec_t;

    vec_t vecs[8];

    // Advance one full clock: through the rising edge to the next falling one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [5:0] instr, input bit ready, input bit az);
        bus.instr_in  = instr;
        bus.mem_ready = ready;
        bus.acc_zero  = az;
    endtask

    task automatic compareVal(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compares every output at once; pc and operand come from the model.
    task automatic checkOutput(input string tag, input bit eMemReq, input logic [1:0] eSrc,
                               input bit eAluEn, input bit eAluOp, input bit eAccWe,
                               input bit eHalted);
        logic [15:0] exp;
        logic [15:0] act;
        exp = {modelPc, eMemReq, eSrc, modelIr[2:0], eAluEn, eAluOp & eAluEn, eAccWe, eHalted};
        act = {bus.pc, bus.mem_req, bus.src_sel, bus.operand, bus.alu_en,
               bus.alu_op & bus.alu_en, bus.acc_we, bus.halted};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got pc=%0d req=%b src=%b opd=%0d alu_en=%b alu_op=%b we=%b hlt=%b, expected pc=%0d req=%b src=%b opd=%0d alu_en=%b alu_op=%b we=%b hlt=%b",
                     tag, $time, act[15:10], act[9], act[8:7], act[6:4], act[3], act[2], act[1], act[0],
                     exp[15:10], exp[9], exp[8:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic noise(input bit az);
        applyStimulus(6'($urandom), 1'($urandom), az);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(6'd0, 1'b0, 1'b0);
        step();
        step();
        modelPc = 6'd0;
        modelIr = 6'd0;
        checkOutput("reset", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Runs one instruction from a FETCH cycle back to the next FETCH cycle
    // (or into HALT), checking every cycle against the per-opcode timeline.
    task automatic runInstr(input logic [5:0] instr, input bit az, input int fetchWaits,
                            input int ldWaits);
        logic [2:0] op;
        op = instr[5:3];
        for (int w = 0; w < fetchWaits; w++) begin
            checkOutput("fetch_wait", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(6'($urandom), 1'b0, az);
            step();
        end
        checkOutput("fetch", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(instr, 1'b1, az);
        step();
        modelIr = instr;
        modelPc = modelPc + 6'd1;

        checkOutput("decode", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        noise(az);
        step();

        case (op)
            3'b110: begin
                if (az) modelPc = {modelPc[5:3], instr[2:0]};
            end
            3'b001, 3'b010: begin
                checkOutput("wb_imm_mov", 1'b0, (op == 3'b001) ? 2'b01 : 2'b00,
                            1'b0, 1'b0, 1'b1, 1'b0);
                noise(az);
                step();
            end
            3'b011, 3'b100: begin
                checkOutput("exec_alu", 1'b0, 2'b10, 1'b1, (op == 3'b100), 1'b0, 1'b0);
                noise(az);
                step();
                checkOutput("wb_alu", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
                noise(az);
                step();
            end
            3'b101: begin
                for (int w = 0; w < ldWaits; w++) begin
                    checkOutput("exec_ld_wait", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
                    applyStimulus(6'($urandom), 1'b0, az);
                    step();
                end
                checkOutput("exec_ld", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
                applyStimulus(6'($urandom), 1'b1, az);
                step();
                checkOutput("wb_ld", 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
                noise(az);
                step();
            end
            default: begin
            end
        endcase
    endtask

    // Observes one zero-wait instruction purely from the outputs: latency is
    // counted until the DUT looks like FETCH again (mem_req with src_sel 00).
    task automatic measureInstr(input logic [5:0] instr, input bit az, output int lat,
                                output int weCount, output logic [1:0] weSrc,
                                output int aluCount, output bit aluOp);
        lat = 1;
        weCount = 0;
        weSrc = 2'b00;
        aluCount = 0;
        aluOp = 1'b0;
        applyStimulus(instr, 1'b1, az);
        step();
        while (!(bus.mem_req && bus.src_sel == 2'b00) && lat < 20) begin
            if (bus.acc_we) begin
                weCount++;
                weSrc = bus.src_sel;
            end
            if (bus.alu_en) begin
                aluCount++;
                aluOp = bus.alu_op;
            end
            applyStimulus(6'($urandom), 1'b1, az);
            step();
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat, weCount, aluCount;
        logic [1:0]  weSrc;
        bit          aluOp;
        logic [5:0]  pcBefore;
        logic [2:0]  rop;

        checks = 0;
        errors = 0;

        vecs[0] = '{6'b001_101, 1'b0, 3, 1, 2'b01, 0, 1'b0};  // LDI 5
        vecs[1] = '{6'b010_011, 1'b0, 3, 1, 2'b00, 0, 1'b0};  // MOV R3
        vecs[2] = '{6'b011_010, 1'b0, 4, 1, 2'b10, 1, 1'b0};  // ADD R2
        vecs[3] = '{6'b100_010, 1'b0, 4, 1, 2'b10, 1, 1'b1};  // SUB R2
        vecs[4] = '{6'b101_001, 1'b0, 4, 1, 2'b11, 0, 1'b0};  // LD
        vecs[5] = '{6'b000_111, 1'b1, 2, 0, 2'b00, 0, 1'b0};  // NOP
        vecs[6] = '{6'b110_101, 1'b0, 2, 0, 2'b00, 0, 1'b0};  // JZ not taken
        vecs[7] = '{6'b110_101, 1'b1, 2, 0, 2'b00, 0, 1'b0};  // JZ taken

        // LDI 5 straight out of reset: acc_we only in cycle 3, pc=1.
        doReset();
        runInstr(6'b001_101, 1'b0, 0, 0);
        compareVal("ldi_pc", int'(bus.pc), 1);

        // Table of zero-wait instructions observed from the outputs only.
        for (int i = 0; i < 8; i++) begin
            measureInstr(vecs[i].instr, vecs[i].az, lat, weCount, weSrc, aluCount, aluOp);
            compareVal($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            compareVal($sformatf("vec%0d_we_count", i), weCount, vecs[i].weCount);
            if (vecs[i].weCount > 0)
                compareVal($sformatf("vec%0d_wb_src", i), int'(weSrc), int'(vecs[i].weSrc));
            compareVal($sformatf("vec%0d_alu_count", i), aluCount, vecs[i].aluCount);
            if (vecs[i].aluCount > 0)
                compareVal($sformatf("vec%0d_alu_op", i), int'(aluOp), int'(vecs[i].aluOp));
        end

        // Random instruction stream with random memory waits and mem_ready noise.
        doReset();
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(6));
            runInstr({rop, 3'($urandom)}, 1'($urandom), int'($urandom_range(2)),
                     int'($urandom_range(3)));
        end

        // LD with three wait cycles in EXEC: seven cycles, pc advances by one.
        pcBefore = modelPc;
        runInstr(6'b101_100, 1'b0, 0, 3);
        compareVal("ld_wait_pc", int'(bus.pc), int'(pcBefore + 6'd1));

        // JZ taken at pc=62 uses the incremented pc's upper bits.
        doReset();
        for (int n = 0; n < 62; n++) runInstr({3'b000, 3'($urandom)}, 1'b0, 0, 0);
        runInstr(6'b110_011, 1'b1, 0, 0);
        compareVal("jz_taken_pc", int'(bus.pc), 59);

        // JZ not taken at pc=62, then the next fetch wraps to 0.
        doReset();
        for (int n = 0; n < 62; n++) runInstr({3'b000, 3'($urandom)}, 1'b0, 0, 0);
        runInstr(6'b110_011, 1'b0, 0, 0);
        compareVal("jz_not_taken_pc", int'(bus.pc), 63);
        runInstr(6'b000_000, 1'b0, 0, 0);
        compareVal("pc_wrap", int'(bus.pc), 0);

        // HLT: absorbing for 20 cycles whatever the inputs do, then reset.
        runInstr(6'b111_000, 1'b0, 0, 0);
        for (int n = 0; n < 20; n++) begin
            checkOutput("halt", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
            noise(1'($urandom));
            step();
        end
        rst = 1'b1;
        step();
        modelPc = 6'd0;
        modelIr = 6'd0;
        checkOutput("halt_reset", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Reset during EXEC of ADD: back to FETCH, no writeback, IR cleared.
        applyStimulus(6'b011_010, 1'b1, 1'b0);
        step();
        modelIr = 6'b011_010;
        modelPc = 6'd1;
        checkOutput("add_decode", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        noise(1'b0);
        step();
        checkOutput("add_exec", 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(6'd0, 1'b0, 1'b0);
        step();
        modelPc = 6'd0;
        modelIr = 6'd0;
        checkOutput("rst_in_exec", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        checkOutput("after_rst_fetch", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
